// File: rtl/arbitro_rr_umbral.sv
// Round-robin reader for the transaction-layer input FIFOs, feeding one downstream FIFO.
// Back-pressure uses hysteresis between the programmed high and low occupancy thresholds.
module arbitro_rr_umbral #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 6,
   parameter int OCC_W  = 4,
   localparam int LANE_W = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               umbral_alto,
   input  logic [2:0]               umbral_bajo,
   input  logic [NUM_IN-1:0]        fifo_empty,
   input  logic [NUM_IN*DATA_W-1:0] fifo_data,
   output logic [NUM_IN-1:0]        fifo_pop,
   input  logic [OCC_W-1:0]         out_occ,
   output logic                     out_push,
   output logic [DATA_W-1:0]        out_data,
   output logic [LANE_W-1:0]        out_lane,
   output logic                     pause,
   output logic                     vacio
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [LANE_W-1:0]   ptr_r;
   logic [LANE_W-1:0]   ptr_next_s;
   logic [LANE_W-1:0]   pop_lane_r;
   logic [LANE_W-1:0]   grant_idx_s;
   logic [LANE_W-1:0]   cand_s;
   logic                grant_found_s;
   logic [NUM_IN-1:0]   pop_next_s;
   logic                pause_next_s;
   logic                all_empty_s;

   assign all_empty_s = &fifo_empty;

   // First non-empty lane at or after ptr, wrapping modulo NUM_IN.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {LANE_W{1'b0}};
      cand_s        = {LANE_W{1'b0}};
      for (int i = 0; i < NUM_IN; i++) begin
         cand_s = ptr_r + LANE_W'(i);
         if (!grant_found_s && !fifo_empty[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Hysteresis: set wins over clear so crossed thresholds act as a plain comparator.
   always_comb begin
      pause_next_s = pause;
      if (out_occ >= OCC_W'(umbral_alto)) begin
         pause_next_s = 1'b1;
      end else if (out_occ <= OCC_W'(umbral_bajo)) begin
         pause_next_s = 1'b0;
      end else begin
         pause_next_s = pause;
      end
   end

   // Next state, next pop strobe and next round-robin pointer.
   always_comb begin
      state_next_s = state_r;
      pop_next_s   = {NUM_IN{1'b0}};
      ptr_next_s   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (pause) begin
               state_next_s = ST_PAUSE;
            end else if (!all_empty_s) begin
               state_next_s = ST_SERVE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (pause) begin
               state_next_s = ST_PAUSE;
            end else if (grant_found_s) begin
               state_next_s = ST_SERVE;
               pop_next_s   = {{(NUM_IN-1){1'b0}}, 1'b1} << grant_idx_s;
               ptr_next_s   = grant_idx_s + {{(LANE_W-1){1'b0}}, 1'b1};
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_PAUSE: begin
            if (pause) begin
               state_next_s = ST_PAUSE;
            end else if (!all_empty_s) begin
               state_next_s = ST_SERVE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, pointer, pause and pop strobe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ptr_r      <= {LANE_W{1'b0}};
         pause      <= 1'b0;
         fifo_pop   <= {NUM_IN{1'b0}};
         pop_lane_r <= {LANE_W{1'b0}};
      end else begin
         state_r  <= state_next_s;
         ptr_r    <= ptr_next_s;
         pause    <= pause_next_s;
         fifo_pop <= pop_next_s;
         if (|pop_next_s) begin
            pop_lane_r <= grant_idx_s;
         end else begin
            pop_lane_r <= pop_lane_r;
         end
      end
   end

   // Read pipeline: the word of the popped lane is forwarded one cycle after the pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_push <= 1'b0;
         out_data <= {DATA_W{1'b0}};
         out_lane <= {LANE_W{1'b0}};
         vacio    <= 1'b1;
      end else begin
         out_push <= |fifo_pop;
         if (|fifo_pop) begin
            out_data <= fifo_data[int'(pop_lane_r)*DATA_W +: DATA_W];
            out_lane <= pop_lane_r;
         end else begin
            out_data <= out_data;
            out_lane <= out_lane;
         end
         vacio <= all_empty_s && (state_r != ST_SERVE) && !(|fifo_pop);
      end
   end

endmodule

// File: tb/tb_arbitro_rr_umbral.sv
// Directed-vector bench for arbitro_rr_umbral: each row drives inputs for one clock
// edge and lists the hand-derived outputs expected just after that edge.
module tb_arbitro_rr_umbral;

   logic        clk;
   logic        reset;
   logic [2:0]  umbral_alto;
   logic [2:0]  umbral_bajo;
   logic [3:0]  fifo_empty;
   logic [23:0] fifo_data;
   logic [3:0]  fifo_pop;
   logic [3:0]  out_occ;
   logic        out_push;
   logic [5:0]  out_data;
   logic [1:0]  out_lane;
   logic        pause;
   logic        vacio;

   int n_checks;
   int n_errors;

   typedef struct {
      logic       rst;
      logic [3:0] e;
      logic [3:0] occ;
      logic [3:0] pop;
      logic       push;
      logic [1:0] lane;
      logic       pz;
      logic       vac;
   } vec_t;

   vec_t vecs[$];

   arbitro_rr_umbral #(.NUM_IN(4), .DATA_W(6), .OCC_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .umbral_alto (umbral_alto),
      .umbral_bajo (umbral_bajo),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_pop    (fifo_pop),
      .out_occ     (out_occ),
      .out_push    (out_push),
      .out_data    (out_data),
      .out_lane    (out_lane),
      .pause       (pause),
      .vacio       (vacio)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] lane_word(input logic [1:0] lane);
      case (lane)
         2'd0:    return 6'h11;
         2'd1:    return 6'h22;
         2'd2:    return 6'h33;
         default: return 6'h0C;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] e, input logic [3:0] occ,
                      input logic [3:0] pop, input logic push, input logic [1:0] lane,
                      input logic pz, input logic vac);
      vec_t v;
      v.rst = rst; v.e = e; v.occ = occ; v.pop = pop;
      v.push = push; v.lane = lane; v.pz = pz; v.vac = vac;
      vecs.push_back(v);
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      clk         = 1'b0;
      reset       = 1'b1;
      umbral_alto = 3'd6;
      umbral_bajo = 3'd2;
      fifo_empty  = 4'b0000;
      out_occ     = 4'd0;
      fifo_data   = {6'h0C, 6'h33, 6'h22, 6'h11};

      //   rst   empty    occ    pop      push  lane  pause vacio
      // reset held two cycles with every lane non-empty
      add(1'b1, 4'b0000, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      add(1'b1, 4'b0000, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      // round robin over all four lanes
      add(1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b0100, 1'b1, 2'd1, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b1000, 1'b1, 2'd2, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b1, 2'd3, 1'b0, 1'b0);
      // only lanes 1 and 3 non-empty
      add(1'b0, 4'b0101, 4'd0, 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0101, 4'd0, 4'b1000, 1'b1, 2'd1, 1'b0, 1'b0);
      add(1'b0, 4'b0101, 4'd0, 4'b0010, 1'b1, 2'd3, 1'b0, 1'b0);
      add(1'b0, 4'b0101, 4'd0, 4'b1000, 1'b1, 2'd1, 1'b0, 1'b0);
      // occupancy ramp up to the high threshold
      add(1'b0, 4'b0000, 4'd1, 4'b0001, 1'b1, 2'd3, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd2, 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd3, 4'b0100, 1'b1, 2'd1, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd4, 4'b1000, 1'b1, 2'd2, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd5, 4'b0001, 1'b1, 2'd3, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd6, 4'b0010, 1'b1, 2'd0, 1'b1, 1'b0);
      // ramp down: held until occupancy reaches the low threshold
      add(1'b0, 4'b0000, 4'd5, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0);
      add(1'b0, 4'b0000, 4'd4, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
      add(1'b0, 4'b0000, 4'd3, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
      add(1'b0, 4'b0000, 4'd2, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd2, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      // resume at saved pointer (lane 2) while occupancy jumps to the high threshold
      add(1'b0, 4'b0000, 4'd6, 4'b0100, 1'b0, 2'd0, 1'b1, 1'b0);
      add(1'b0, 4'b0000, 4'd6, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0);
      // all lanes empty: pause releases, PAUSE then IDLE, vacio raised
      add(1'b0, 4'b1111, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      // lane 0 only: pointer 3 wraps to lane 0, then reset lands on the in-flight read
      add(1'b0, 4'b1110, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b1110, 4'd0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b1, 4'b1111, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
      // pointer back at lane 0 after reset
      add(1'b0, 4'b0000, 4'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      add(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         reset      = vecs[i].rst;
         fifo_empty = vecs[i].e;
         out_occ    = vecs[i].occ;
         @(posedge clk);
         #1;
         check_val($sformatf("pop[%0d]", i),   32'(fifo_pop), 32'(vecs[i].pop));
         check_val($sformatf("push[%0d]", i),  32'(out_push), 32'(vecs[i].push));
         check_val($sformatf("pause[%0d]", i), 32'(pause),    32'(vecs[i].pz));
         check_val($sformatf("vacio[%0d]", i), 32'(vacio),    32'(vecs[i].vac));
         if (vecs[i].push) begin
            check_val($sformatf("lane[%0d]", i), 32'(out_lane), 32'(vecs[i].lane));
            check_val($sformatf("data[%0d]", i), 32'(out_data), 32'(lane_word(vecs[i].lane)));
         end else begin
            n_checks = n_checks;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/arbitro_rr_umbral.md
Name: arbitro_rr_umbral

Overview:
- Reader side of the transaction-layer input FIFOs.
- Drains NUM_IN input FIFOs into a single downstream FIFO. Grants one lane per cycle, round-robin.
- Applies hysteresis back-pressure on downstream occupancy, using the high/low thresholds programmed by the control FSM.
- Reports when it has nothing to serve.

Parameters:
NUM_IN, 4, number of input FIFO lanes (power of two, 2..8)
DATA_W, 6, word width per lane
OCC_W, 4, width of downstream occupancy count (downstream depth 8)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
umbral_alto  input  3  pause-assert threshold (from FSM interno_alto)
umbral_bajo  input  3  pause-release threshold (from FSM interno_bajo)
fifo_empty  input  NUM_IN  per-lane empty flag, 1 = empty
fifo_data  input  NUM_IN*DATA_W  lane i at bits [i*DATA_W +: DATA_W]; valid one cycle after pop
fifo_pop  output  NUM_IN  one-hot read strobe, or all zero
out_occ  input  OCC_W  downstream FIFO occupancy, 0..8
out_push  output  1  downstream write strobe
out_data  output  DATA_W  word pushed downstream
out_lane  output  log2(NUM_IN)  source lane of out_data
pause  output  1  back-pressure active
vacio  output  1  all lanes empty and no read in flight

Behaviour:
- Reset, registered on the clk edge where reset=1:
  - fifo_pop=0, out_push=0, out_data=0, out_lane=0, pause=0, vacio=1.
  - Round-robin pointer ptr=0. State=IDLE. Any read in flight is discarded, so no push follows.
- Pause register, hysteresis evaluated every cycle from out_occ:
  - Set when out_occ >= umbral_alto (zero-extended).
  - Cleared when out_occ <= umbral_bajo and out_occ < umbral_alto.
  - Otherwise holds.
  - Set has priority, so umbral_bajo >= umbral_alto degenerates to a plain comparator and never oscillates within one cycle.
  - Legal configuration: umbral_alto <= 6, leaving 2 entries of margin for in-flight words.
- States:
  - IDLE: fifo_pop=0.
    - -> SERVE when any fifo_empty bit is 0 and pause=0.
    - -> PAUSE when pause=1.
  - SERVE: each cycle, select the first lane with fifo_empty=0, searching from ptr upward and wrapping modulo NUM_IN.
    - Assert that lane's fifo_pop bit (registered, one cycle wide); then ptr <= granted+1 (mod NUM_IN).
    - No eligible lane -> IDLE, no pop.
    - pause=1 -> PAUSE, no pop issued in that cycle.
  - PAUSE: fifo_pop=0.
    - -> SERVE when pause=0 and a lane is non-empty.
    - -> IDLE when pause=0 and all lanes are empty.
- Read pipeline:
  - Pop of lane k visible at edge N.
  - At edge N+1: out_push=1, out_data=fifo_data lane k, out_lane=k.
  - Latency 1 cycle. Sustained throughput 1 word/cycle.
  - The in-flight read always completes, even if pause rises or the state leaves SERVE.
- Never pop a lane whose fifo_empty=1 in the same cycle.
- Maximum one pop per cycle. Never two consecutive pops to the same lane while another lane is non-empty.
- vacio=1 iff all fifo_empty=1, state != SERVE and out_push will not fire next edge. Registered, reflects the previous cycle's inputs.
- ptr does not change in IDLE or PAUSE, so fairness resumes where it stopped.
- Threshold inputs are used live; changes take effect on the next pause evaluation.

Test Plan:
- Reset: hold reset=1 for 2 cycles with lanes non-empty -> fifo_pop=0, out_push=0, pause=0, vacio=1; first pop to lane 0 appears 1 cycle after reset drops.
- Round-robin: all 4 lanes non-empty, out_occ=0, alto=6, bajo=2 -> pops lanes 0,1,2,3,0… each cycle; out_lane follows 1 cycle later with the matching fifo_data word.
- Skip empties: only lanes 1 and 3 non-empty -> pops alternate 1,3,1,3; lanes 0 and 2 are never strobed.
- Hysteresis: alto=6, bajo=2; ramp out_occ 0→6 -> pause=1 and pops stop the cycle after; out_occ 5,4,3 -> still paused; out_occ=2 -> pause=0 and pops resume from the saved ptr.
- Pause during in-flight read: pop of lane 2 at cycle N, out_occ hits alto at N -> out_push for lane 2 still fires at N+1; no pop at N+1.
- Reset mid-operation: assert reset the cycle after a pop -> no out_push for that read; ptr=0 afterwards; vacio=1 while all fifo_empty=1.
